arbitro_memoria_dados: RTL

//  Two-requester arbiter/sequencer for the single-port 16x16 data memory. Port A is the

---
 rtl/arbitro_memoria_dados.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arbitro_memoria_dados.sv
// Two-requester round-robin arbiter/sequencer for the single-port 16x16 data memory.
// Port A is the processor load/store path, port B the secondary master (debug/DMA).
// One transaction at a time: IDLE -> ACCESS -> READ -> DONE, with a one-cycle ack.
module arbitro_memoria_dados #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    // port A
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    // port B
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    // memory pins
    output logic                  mem_wren,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_q,
    // status
    output logic                  busy,
    output logic                  grant_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READ   = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    wren_q, wren_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    grant_b_q, grant_b_d;
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic [DATA_WIDTH-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0]   rdata_b_q, rdata_b_d;
    logic                    busy_q, busy_d;
    logic                    win_b;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        wren_d    = wren_q;
        addr_d    = addr_q;
        din_d     = din_q;
        grant_b_d = grant_b_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        // B wins when it is the sole requester, or on a tie when A owned the last grant
        win_b     = req_b && (!req_a || !grant_b_q);

        case (state_q)
            IDLE: begin
                wren_d = 1'b0;
                if (req_a || req_b) begin
                    wren_d    = win_b ? we_b    : we_a;
                    addr_d    = win_b ? addr_b  : addr_a;
                    din_d     = win_b ? wdata_b : wdata_a;
                    grant_b_d = win_b;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // memory samples the pins at this edge; keep the write strobe to one cycle
                wren_d  = 1'b0;
                state_d = READ;
            end
            READ: begin
                if (grant_b_q) begin
                    rdata_b_d = mem_q;
                    ack_b_d   = 1'b1;
                end else begin
                    rdata_a_d = mem_q;
                    ack_a_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            grant_b_q <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            grant_b_q <= grant_b_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_wren    = wren_q;
    assign mem_address = addr_q;
    assign mem_din     = din_q;
    assign grant_b     = grant_b_q;
    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign busy        = busy_q;

endmodule
